// File: rtl/deserializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : deserializer_pkg
// Description : Shared control-group helpers for the SPI frame deserializer:
//               width derivation and FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package deserializer_pkg;

    // Ceiling log2. A result of 0 is returned for values of 0 and 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Total bits on the wire per frame: opcode followed by address.
    function automatic int shift_width(input int opcode_w, input int addr_w);
        return opcode_w + addr_w;
    endfunction

    // The bit counter must be able to hold the value SHIFT_W itself.
    function automatic int cnt_width(input int shift_w);
        return clog2(shift_w + 1);
    endfunction

    // Receive FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Single-bit two-flop synchronizer with a selectable reset
//               value, used to bring the SPI pins into the clk domain.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic r_s1;
    logic r_s2;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= RST_VAL;
            r_s2 <= RST_VAL;
        end else begin
            r_s1 <= d;
            r_s2 <= r_s1;
        end
    end

    assign q = r_s2;

endmodule
`default_nettype wire

// File: rtl/deserializer.sv
`default_nettype none
// ============================================================================
// Module      : deserializer
// Description : Receives MSB-first {opcode, addr} frames from a chip-select
//               framed SPI link, oversampled in the clk domain, and hands
//               them downstream through a one-entry valid/ready holding
//               register. Flags aborted frames and frames dropped because
//               the holding register was still occupied.
// Revision    : 1.0 - initial release
// ============================================================================
module deserializer
    import deserializer_pkg::*;
#(
    parameter int ADDRW   = 8,
    parameter int OPCODEW = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               spi_clk,
    input  logic               cs_n,
    input  logic               mosi,
    input  logic               ready_in,
    output logic               valid_out,
    output logic [OPCODEW-1:0] opcode_out,
    output logic [ADDRW-1:0]   addr_out,
    output logic               err_short,
    output logic               err_overrun
);

    localparam int SHIFT_W = shift_width(OPCODEW, ADDRW);
    localparam int CNT_W   = cnt_width(SHIFT_W);

    // Counter value while the final bit of a frame is being received.
    localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(SHIFT_W - 1);

    // ------------------------------------------------------------------
    // Synchronized SPI pins
    // ------------------------------------------------------------------
    logic w_sclk_s2;
    logic w_cs_s2;
    logic w_mosi_s2;
    logic r_sclk_s3;
    logic w_rise;

    sync_2ff #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (spi_clk),
        .q     (w_sclk_s2)
    );

    // Chip select resets to the deasserted level so a reset never looks
    // like the start of a frame.
    sync_2ff #(.RST_VAL(1'b1)) u_sync_cs (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cs_n),
        .q     (w_cs_s2)
    );

    sync_2ff #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (mosi),
        .q     (w_mosi_s2)
    );

    // Third spi_clk stage, delayed copy for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_s3 <= 1'b0;
        end else begin
            r_sclk_s3 <= w_sclk_s2;
        end
    end

    assign w_rise = w_sclk_s2 & ~r_sclk_s3;

    // ------------------------------------------------------------------
    // Frame FSM, bit counter and shifter
    // ------------------------------------------------------------------
    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [SHIFT_W-1:0]    r_shift;
    logic [SHIFT_W-1:0]    w_frame;
    logic                  w_shift_en;
    logic                  w_cnt_clr;
    logic                  w_commit;
    logic                  w_abort;
    logic                  w_load;

    // Shifted value including the bit sampled on the current rise; this is
    // what gets committed when the last bit arrives.
    assign w_frame = (r_shift << 1) | SHIFT_W'(w_mosi_s2);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-cycle control decode. Chip-select deassertion takes
    // priority over a coincident rise: the frame is over either way.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_en  = 1'b0;
        w_cnt_clr   = 1'b0;
        w_commit    = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_cs_s2) begin
                    w_state_nxt = ST_SHIFT;
                    w_cnt_clr   = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (w_cs_s2) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_clr   = 1'b1;
                    w_abort     = (r_cnt != '0);
                end else if (w_rise) begin
                    w_shift_en = 1'b1;
                    if (r_cnt == C_LAST_CNT) begin
                        w_commit    = 1'b1;
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_cs_s2) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Bit counter and shift register; both start clean for every frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (w_cnt_clr) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (w_shift_en) begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_shift <= w_frame;
        end
    end

    // ------------------------------------------------------------------
    // Holding register and error pulses
    // ------------------------------------------------------------------

    // A completed frame is accepted if the slot is empty or is being read
    // in this very cycle; otherwise it is dropped and the held data kept.
    assign w_load = w_commit & (~valid_out | ready_in);

    // Holding register with valid/ready handshake plus registered flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out   <= 1'b0;
            opcode_out  <= '0;
            addr_out    <= '0;
            err_short   <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_short   <= w_abort;
            err_overrun <= w_commit & ~w_load;
            if (w_load) begin
                valid_out  <= 1'b1;
                opcode_out <= w_frame[SHIFT_W-1 -: OPCODEW];
                addr_out   <= w_frame[ADDRW-1:0];
            end else if (valid_out && ready_in) begin
                valid_out <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_deserializer
// Description : Self-checking bench for deserializer: directed scenarios
//               followed by randomized frames compared against a frame-level
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_deserializer;

    localparam int ADDRW   = 8;
    localparam int OPCODEW = 2;
    localparam int SHIFT_W = OPCODEW + ADDRW;

    logic               clk      = 1'b0;
    logic               rst_n    = 1'b0;
    logic               spi_clk  = 1'b0;
    logic               cs_n     = 1'b1;
    logic               mosi     = 1'b0;
    logic               ready_in = 1'b0;
    logic               valid_out;
    logic [OPCODEW-1:0] opcode_out;
    logic [ADDRW-1:0]   addr_out;
    logic               err_short;
    logic               err_overrun;

    deserializer #(.ADDRW(ADDRW), .OPCODEW(OPCODEW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi_clk     (spi_clk),
        .cs_n        (cs_n),
        .mosi        (mosi),
        .ready_in    (ready_in),
        .valid_out   (valid_out),
        .opcode_out  (opcode_out),
        .addr_out    (addr_out),
        .err_short   (err_short),
        .err_overrun (err_overrun)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;
    int cyc   = 0;
    int last_rise_cyc = 0;
    int valid_rise_cyc = -1;
    int n_short = 0;
    int n_ovr   = 0;

    logic [SHIFT_W-1:0] q_obs[$];
    logic [SHIFT_W-1:0] q_exp[$];

    logic               prev_hold  = 1'b0;
    logic               prev_valid = 1'b0;
    logic [SHIFT_W-1:0] prev_data  = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: collects transfers, counts error pulses and checks
    // that held data stays put while the consumer is not ready.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_hold) begin
                chk("hold_valid", valid_out, 1);
                chk("hold_data", {opcode_out, addr_out}, prev_data);
            end
            if (valid_out && !prev_valid) valid_rise_cyc <= cyc;
            if (valid_out && ready_in) q_obs.push_back({opcode_out, addr_out});
            if (err_short) n_short <= n_short + 1;
            if (err_overrun) n_ovr <= n_ovr + 1;
            prev_hold  <= valid_out && !ready_in;
            prev_valid <= valid_out;
            prev_data  <= {opcode_out, addr_out};
        end else begin
            prev_hold  <= 1'b0;
            prev_valid <= 1'b0;
        end
    end

    // Advance n clocks, landing 3 ns after the rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #3;
        end
    endtask

    // Send nbits MSB-first inside one chip-select window. With rdy_pulse set,
    // ready_in is raised for exactly the clock in which the last bit commits.
    task automatic send(input int nbits, input logic [31:0] bits, input int half, input bit rdy_pulse);
        cs_n = 1'b0;
        tick(3);
        for (int i = nbits - 1; i >= 0; i--) begin
            mosi = bits[i];
            tick(half);
            spi_clk = 1'b1;
            last_rise_cyc = cyc;
            if (rdy_pulse && i == 0) begin
                tick(2);
                ready_in = 1'b1;
                tick(1);
                ready_in = 1'b0;
                tick(half - 3);
            end else begin
                tick(half);
            end
            spi_clk = 1'b0;
        end
        tick(3);
        cs_n = 1'b1;
        tick(4);
    endtask

    // Drain both queues, comparing delivered frames with the model's list.
    task automatic check_q(input string tag);
        logic [SHIFT_W-1:0] e;
        chk({tag, "_count"}, q_obs.size(), q_exp.size());
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            if (q_obs.size() > 0) chk(tag, q_obs.pop_front(), e);
        end
        q_obs.delete();
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_valid"}, valid_out, 0);
        chk({tag, "_opcode"}, opcode_out, 0);
        chk({tag, "_addr"}, addr_out, 0);
        chk({tag, "_err_short"}, err_short, 0);
        chk({tag, "_err_overrun"}, err_overrun, 0);
    endtask

    int                 s0;
    int                 o0;
    int                 exp_short;
    int                 len;
    int                 half;
    int                 kind;
    logic [OPCODEW-1:0] r_op;
    logic [ADDRW-1:0]   r_addr;
    logic [31:0]        b;
    logic [31:0]        frame32;

    initial begin
        // Reset state
        tick(3);
        chk_zero_outputs("reset");
        rst_n = 1'b1;
        tick(3);

        // Single frame, ready held high, latency check
        ready_in = 1'b1;
        s0 = n_short; o0 = n_ovr;
        q_exp.push_back({2'b10, 8'hA5});
        send(SHIFT_W, 32'({2'b10, 8'hA5}), 5, 1'b0);
        tick(4);
        chk("t1_latency", valid_rise_cyc, last_rise_cyc + 3);
        check_q("t1_frame");
        chk("t1_short", n_short - s0, 0);
        chk("t1_ovr", n_ovr - o0, 0);

        // Backpressure: second frame dropped with one overrun pulse
        ready_in = 1'b0;
        o0 = n_ovr;
        send(SHIFT_W, 32'({2'b01, 8'h3C}), 4, 1'b0);
        send(SHIFT_W, 32'({2'b11, 8'hFF}), 4, 1'b0);
        chk("t2_valid", valid_out, 1);
        chk("t2_data", {opcode_out, addr_out}, {2'b01, 8'h3C});
        chk("t2_ovr", n_ovr - o0, 1);
        ready_in = 1'b1;
        tick(3);
        chk("t2_drained", valid_out, 0);
        q_exp.push_back({2'b01, 8'h3C});
        check_q("t2_frame");
        ready_in = 1'b0;

        // Read of held frame A in the exact cycle frame B commits
        o0 = n_ovr;
        send(SHIFT_W, 32'({2'b00, 8'h11}), 5, 1'b0);
        send(SHIFT_W, 32'({2'b11, 8'h22}), 5, 1'b1);
        chk("t3_valid", valid_out, 1);
        chk("t3_data", {opcode_out, addr_out}, {2'b11, 8'h22});
        chk("t3_ovr", n_ovr - o0, 0);
        q_exp.push_back({2'b00, 8'h11});
        check_q("t3_a");
        ready_in = 1'b1;
        tick(3);
        q_exp.push_back({2'b11, 8'h22});
        check_q("t3_b");

        // Short frame then a good frame
        s0 = n_short;
        send(5, 32'b10110, 4, 1'b0);
        chk("t4_short", n_short - s0, 1);
        chk("t4_no_valid", q_obs.size(), 0);
        q_exp.push_back({2'b00, 8'h01});
        send(SHIFT_W, 32'({2'b00, 8'h01}), 4, 1'b0);
        tick(2);
        check_q("t4_frame");
        chk("t4_short_once", n_short - s0, 1);

        // Extra clocks after the frame is complete
        s0 = n_short; o0 = n_ovr;
        q_exp.push_back({2'b11, 8'h5A});
        send(SHIFT_W + 2, 32'({2'b11, 8'h5A, 2'b10}), 4, 1'b0);
        tick(2);
        check_q("t5_frame");
        chk("t5_short", n_short - s0, 0);
        chk("t5_ovr", n_ovr - o0, 0);

        // Reset in the middle of a frame
        s0 = n_short;
        cs_n = 1'b0;
        tick(3);
        for (int i = 0; i < 4; i++) begin
            mosi = i[0];
            tick(4);
            spi_clk = 1'b1;
            tick(4);
            spi_clk = 1'b0;
        end
        rst_n = 1'b0;
        tick(2);
        chk_zero_outputs("t6_in_reset");
        cs_n = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        chk_zero_outputs("t6_after");
        q_exp.push_back({2'b10, 8'hC3});
        send(SHIFT_W, 32'({2'b10, 8'hC3}), 4, 1'b0);
        tick(2);
        check_q("t6_frame");
        chk("t6_short", n_short - s0, 0);

        // Randomized frames: a frame of SHIFT_W or more bits delivers its
        // first SHIFT_W bits; fewer bits (but at least one) is an abort.
        s0 = n_short; o0 = n_ovr;
        exp_short = 0;
        for (int k = 0; k < 16; k++) begin
            r_op   = OPCODEW'($urandom_range(0, 3));
            r_addr = ADDRW'($urandom_range(0, 255));
            half   = int'($urandom_range(3, 7));
            kind   = int'($urandom_range(0, 3));
            if (kind == 0) begin
                len = int'($urandom_range(1, SHIFT_W - 1));
                b   = $urandom;
                exp_short++;
            end else begin
                len = SHIFT_W + int'($urandom_range(0, 3));
                frame32 = 32'({r_op, r_addr});
                b = (frame32 << (len - SHIFT_W)) | ($urandom & ((32'd1 << (len - SHIFT_W)) - 32'd1));
                q_exp.push_back({r_op, r_addr});
            end
            send(len, b, half, 1'b0);
        end
        tick(2);
        check_q("rand_frame");
        chk("rand_short", n_short - s0, exp_short);
        chk("rand_ovr", n_ovr - o0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
